// File: rtl/clock_set_ctrl.sv
// Clock-of-day keeper with push-button time setting.
// Time is stored as six BCD digits; a four-state FSM selects which field btn_inc edits.
module clock_set_ctrl #(
  parameter int IDLE_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hour1,
  output logic [3:0] hour0,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [2:0] edit_field,
  output logic       day_carry
);

  localparam int IW = (IDLE_TICKS < 32) ? 5 : $clog2(IDLE_TICKS + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TICKS - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [IW-1:0] r_idle;
  logic [IW-1:0] w_idle_next;
  logic [2:0]    r_edit_field;
  logic          r_day_carry;

  logic [7:0] r_hour;
  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic [7:0] w_hour_next;
  logic [7:0] w_min_next;
  logic [7:0] w_sec_next;

  logic w_run_tick;
  logic w_midnight;
  logic w_timeout;
  logic w_edit_inc;

  // {tens, units} increment for minutes/seconds, 59 wraps to 00.
  function automatic logic [7:0] inc_sexa(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v == 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [2:0] field_of(input state_t s);
    logic [2:0] f;
    case (s)
      SET_HOUR: f = 3'b100;
      SET_MIN:  f = 3'b010;
      SET_SEC:  f = 3'b001;
      default:  f = 3'b000;
    endcase
    return f;
  endfunction

  assign w_run_tick = (r_state == RUN) && enable && tick_1hz;
  assign w_midnight = w_run_tick && (r_hour == 8'h23) && (r_min == 8'h59) && (r_sec == 8'h59);
  // btn_mode wins over btn_inc when both arrive together.
  assign w_edit_inc = btn_inc && !btn_mode;
  // The tick that would bring the idle count to IDLE_TICKS ends the edit session.
  assign w_timeout  = (r_state != RUN) && tick_1hz && !btn_inc && !btn_mode && (r_idle == IDLE_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (btn_mode) w_state_next = SET_HOUR;
      end
      SET_HOUR: begin
        if (btn_mode)       w_state_next = SET_MIN;
        else if (w_timeout) w_state_next = RUN;
      end
      SET_MIN: begin
        if (btn_mode)       w_state_next = SET_SEC;
        else if (w_timeout) w_state_next = RUN;
      end
      SET_SEC: begin
        if (btn_mode || w_timeout) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  always_comb begin
    w_idle_next = r_idle;
    if ((r_state == RUN) || (w_state_next != r_state) || btn_mode || btn_inc) begin
      w_idle_next = '0;
    end else if (tick_1hz) begin
      w_idle_next = r_idle + IW'(1);
    end
  end

  always_comb begin
    w_hour_next = r_hour;
    w_min_next  = r_min;
    w_sec_next  = r_sec;
    if (w_run_tick) begin
      w_sec_next = inc_sexa(r_sec);
      if (r_sec == 8'h59) begin
        w_min_next = inc_sexa(r_min);
        if (r_min == 8'h59) w_hour_next = inc_hour(r_hour);
      end
    end else if (w_edit_inc) begin
      case (r_state)
        SET_HOUR: w_hour_next = inc_hour(r_hour);
        SET_MIN:  w_min_next  = inc_sexa(r_min);
        SET_SEC:  w_sec_next  = 8'h00;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= RUN;
      r_idle       <= '0;
      r_edit_field <= 3'b000;
      r_day_carry  <= 1'b0;
      r_hour       <= 8'h00;
      r_min        <= 8'h00;
      r_sec        <= 8'h00;
    end else begin
      r_state      <= w_state_next;
      r_idle       <= w_idle_next;
      r_edit_field <= field_of(w_state_next);
      r_day_carry  <= w_midnight;
      r_hour       <= w_hour_next;
      r_min        <= w_min_next;
      r_sec        <= w_sec_next;
    end
  end

  assign hour1      = r_hour[7:4];
  assign hour0      = r_hour[3:0];
  assign min1       = r_min[7:4];
  assign min0       = r_min[3:0];
  assign sec1       = r_sec[7:4];
  assign sec0       = r_sec[3:0];
  assign edit_field = r_edit_field;
  assign day_carry  = r_day_carry;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: table of vectors, directed corner sequences and random
// stimulus checked against a seconds-of-day reference model.
module tb_clock_set_ctrl;

  localparam int IDLE = 30;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] hour1, hour0, min1, min0, sec1, sec0;
  logic [2:0] edit_field;
  logic       day_carry;

  int total;
  int bad;

  // Reference model: time as seconds since midnight, mode 0=RUN 1=hour 2=min 3=sec.
  int   m_t;
  int   m_st;
  int   m_idle;
  logic m_carry;

  clock_set_ctrl #(.IDLE_TICKS(IDLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tick_1hz   (tick_1hz),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .hour1      (hour1),
    .hour0      (hour0),
    .min1       (min1),
    .min0       (min0),
    .sec1       (sec1),
    .sec0       (sec0),
    .edit_field (edit_field),
    .day_carry  (day_carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic m, i, t, e;
    int   hh, mm, ss;
    logic [2:0] f;
    logic c;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  function automatic logic [23:0] pack(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] dut_time();
    return {hour1, hour0, min1, min0, sec1, sec0};
  endfunction

  function automatic logic [2:0] model_field();
    case (m_st)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_st = 0; m_idle = 0; m_carry = 1'b0;
  endtask

  task automatic model_update(input logic m, input logic i, input logic t, input logic e);
    int h, mi, s;
    m_carry = 1'b0;
    if (m_st == 0) begin
      if (e && t) begin
        m_t = (m_t + 1) % 86400;
        m_carry = (m_t == 0);
      end
      if (m) m_st = 1;
      m_idle = 0;
    end else if (m) begin
      m_st = (m_st + 1) % 4;
      m_idle = 0;
    end else if (i) begin
      h  = m_t / 3600;
      mi = (m_t / 60) % 60;
      s  = m_t % 60;
      case (m_st)
        1:       h  = (h + 1) % 24;
        2:       mi = (mi + 1) % 60;
        default: s  = 0;
      endcase
      m_t = h * 3600 + mi * 60 + s;
      m_idle = 0;
    end else if (t) begin
      m_idle++;
      if (m_idle == IDLE) begin
        m_st = 0;
        m_idle = 0;
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_time"},  32'(dut_time()), 32'(pack(m_t / 3600, (m_t / 60) % 60, m_t % 60)));
    chk({tag, "_field"}, 32'(edit_field), 32'(model_field()));
    chk({tag, "_carry"}, 32'(day_carry),  32'(m_carry));
  endtask

  // One clock cycle with the given pulses; results checked #1 after the edge.
  task automatic step(input logic m, input logic i, input logic t, input logic e);
    btn_mode = m; btn_inc = i; tick_1hz = t; enable = e;
    @(posedge clk);
    model_update(m, i, t, e);
    #1;
    btn_mode = 1'b0; btn_inc = 1'b0; tick_1hz = 1'b0;
    cmp_model("step");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_mode = 1'b0; btn_inc = 1'b0; tick_1hz = 1'b0; enable = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_time",  32'(dut_time()), 32'h0);
    chk("reset_field", 32'(edit_field), 32'h0);
    chk("reset_carry", 32'(day_carry),  32'h0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    total = 0; bad = 0;
    model_reset();

    //            m  i  t  e  hh mm ss field   carry
    tbl[0]  = '{1, 0, 0, 1, 0, 0, 0, 3'b100, 0};
    tbl[1]  = '{0, 1, 0, 1, 1, 0, 0, 3'b100, 0};
    tbl[2]  = '{0, 1, 1, 1, 2, 0, 0, 3'b100, 0};
    tbl[3]  = '{0, 1, 0, 1, 3, 0, 0, 3'b100, 0};
    tbl[4]  = '{1, 1, 0, 1, 3, 0, 0, 3'b010, 0};
    tbl[5]  = '{0, 1, 0, 1, 3, 1, 0, 3'b010, 0};
    tbl[6]  = '{0, 0, 1, 1, 3, 1, 0, 3'b010, 0};
    tbl[7]  = '{1, 0, 0, 1, 3, 1, 0, 3'b001, 0};
    tbl[8]  = '{0, 1, 0, 1, 3, 1, 0, 3'b001, 0};
    tbl[9]  = '{1, 0, 0, 1, 3, 1, 0, 3'b000, 0};
    tbl[10] = '{0, 0, 1, 1, 3, 1, 1, 3'b000, 0};
    tbl[11] = '{0, 0, 1, 0, 3, 1, 1, 3'b000, 0};
    tbl[12] = '{0, 1, 0, 1, 3, 1, 1, 3'b000, 0};
    tbl[13] = '{0, 0, 1, 1, 3, 1, 2, 3'b000, 0};

    do_reset();
    for (int k = 0; k < NV; k++) begin
      step(tbl[k].m, tbl[k].i, tbl[k].t, tbl[k].e);
      chk("vec_time",  32'(dut_time()), 32'(pack(tbl[k].hh, tbl[k].mm, tbl[k].ss)));
      chk("vec_field", 32'(edit_field), 32'(tbl[k].f));
      chk("vec_carry", 32'(day_carry),  32'(tbl[k].c));
    end

    // Full set sequence with wrap of hour and minute fields.
    do_reset();
    step(1, 0, 0, 1);
    for (int k = 0; k < 25; k++) step(0, 1, 0, 1);
    chk("set_hour", 32'({hour1, hour0}), 32'h01);
    chk("set_hour_field", 32'(edit_field), 32'b100);
    step(1, 0, 0, 1);
    for (int k = 0; k < 61; k++) step(0, 1, 0, 1);
    chk("set_min", 32'({min1, min0}), 32'h01);
    chk("set_min_field", 32'(edit_field), 32'b010);
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);
    chk("set_sec", 32'({sec1, sec0}), 32'h00);
    step(1, 0, 0, 1);
    chk("set_run_field", 32'(edit_field), 32'b000);

    // Rollover from 23:59:58.
    do_reset();
    step(1, 0, 0, 1);
    for (int k = 0; k < 23; k++) step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    for (int k = 0; k < 59; k++) step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    for (int k = 0; k < 58; k++) step(0, 0, 1, 1);
    chk("roll_pre", 32'(dut_time()), 32'h235958);
    step(0, 0, 1, 1);
    chk("roll_59", 32'(dut_time()), 32'h235959);
    chk("roll_59_carry", 32'(day_carry), 32'h0);
    step(0, 0, 1, 1);
    chk("roll_00", 32'(dut_time()), 32'h000000);
    chk("roll_carry_hi", 32'(day_carry), 32'h1);
    step(0, 0, 0, 1);
    chk("roll_carry_lo", 32'(day_carry), 32'h0);

    // Freeze in SET_MIN and in RUN with enable low.
    do_reset();
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);
    for (int k = 0; k < 10; k++) step(0, 0, 1, 1);
    chk("freeze_set", 32'(dut_time()), 32'h020100);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    for (int k = 0; k < 10; k++) step(0, 0, 1, 0);
    chk("freeze_run", 32'(dut_time()), 32'h020100);

    // Idle timeout, then again with a btn_inc after tick 20.
    do_reset();
    step(1, 0, 0, 1);
    for (int k = 0; k < 29; k++) step(0, 0, 1, 1);
    chk("idle_29", 32'(edit_field), 32'b100);
    step(0, 0, 1, 1);
    chk("idle_30", 32'(edit_field), 32'b000);
    step(1, 0, 0, 1);
    for (int k = 0; k < 20; k++) step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    for (int k = 0; k < 29; k++) step(0, 0, 1, 1);
    chk("idle_49", 32'(edit_field), 32'b100);
    step(0, 0, 1, 1);
    chk("idle_50", 32'(edit_field), 32'b000);
    chk("idle_keep_time", 32'(dut_time()), 32'h010000);

    // Simultaneous mode and inc at hour 05.
    do_reset();
    step(1, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    chk("simul_field", 32'(edit_field), 32'b010);
    chk("simul_hour", 32'({hour1, hour0}), 32'h05);

    // Timeout and btn_mode together in SET_SEC.
    step(1, 0, 0, 1);
    for (int k = 0; k < 29; k++) step(0, 0, 1, 1);
    step(1, 0, 1, 1);
    chk("sec_mode_timeout", 32'(edit_field), 32'b000);

    // Async reset mid-edit without a clock edge.
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_time", 32'(dut_time()), 32'h0);
    chk("async_field", 32'(edit_field), 32'h0);
    #1 reset = 1'b0;
    model_reset();
    step(0, 0, 1, 1);

    // Random stimulus against the model.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      step(logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
